panel_status_monitor: RTL and testbench

//  Parametrised status/health monitor for Barco NX4 panel drivers; generalises the ad-hoc blank

---
 rtl/panel_status_monitor_pkg.sv | 19 +
 rtl/xerr_stretch.sv | 67 ++++++
 rtl/panel_status_monitor.sv | 105 ++++++++++
 tb/tb_panel_status_monitor.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/panel_status_monitor_pkg.sv
// Shared constants for the panel status monitor: the production defaults for the
// watchdog, error stretch and period counter, plus the fixed frame counter width.
package panel_status_monitor_pkg;

    localparam int FRAME_COUNT_W           = 16;
    localparam int DEF_CHANNELS            = 2;
    localparam int DEF_BLINK_BIT           = 9;
    localparam int DEF_PERIOD_W            = 20;
    localparam int DEF_WATCHDOG_CYCLES     = 500000;
    localparam int DEF_ERR_HOLD            = 2000000;

    typedef logic [FRAME_COUNT_W-1:0] frame_count_t;

    // Bits needed for a down-counter that is loaded with 'hold' and runs to zero.
    function automatic int hold_width(input int hold);
        return $clog2(hold + 1);
    endfunction

endpackage

// File: rtl/xerr_stretch.sv
// One XERR channel: synchronises the asynchronous active-low XERR line, stretches
// each error sample into a retriggerable hold window and keeps a sticky error bit.
module xerr_stretch
    import panel_status_monitor_pkg::*;
#(
    parameter int ERR_HOLD = DEF_ERR_HOLD
) (
    input  logic clock,
    input  logic reset_n,
    input  logic xerr_n,
    input  logic clear,
    output logic active,
    output logic sticky
);

    localparam int HOLD_W = hold_width(ERR_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ERR_HOLD);

    logic              sync1_q, sync2_q;
    logic              err;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              sticky_q, sticky_d;

    // Two-flop synchroniser carrying the error in active-high form.
    // NOTE: the inverted line is synchronised so a reset value of 0 means "no error";
    // resetting flops that hold raw xerr_n to 0 would fake an error after release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the old values,
            // which is what turns two statements into a two-stage shift.
            sync1_q <= ~xerr_n;
            sync2_q <= sync1_q;
        end
    end

    assign err = sync2_q;

    // Next state of the hold counter and sticky bit; an error sample wins over clear.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        hold_d   = hold_q;
        sticky_d = err | (sticky_q & ~clear);
        if (err) begin
            hold_d = HOLD_LOAD;
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end
    end

    // Hold counter and sticky state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_q   <= '0;
            sticky_q <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            sticky_q <= sticky_d;
        end
    end

    assign active = (hold_q != '0);
    assign sticky = sticky_q;

endmodule

// File: rtl/panel_status_monitor.sv
// Panel driver health monitor: blank heartbeat, frame period measurement, frame
// counter, blank watchdog and stretched per-channel XERR reporting.
module panel_status_monitor
    import panel_status_monitor_pkg::*;
#(
    parameter int CHANNELS        = DEF_CHANNELS,
    parameter int BLINK_BIT       = DEF_BLINK_BIT,
    parameter int PERIOD_W        = DEF_PERIOD_W,
    parameter int WATCHDOG_CYCLES = DEF_WATCHDOG_CYCLES,
    parameter int ERR_HOLD        = DEF_ERR_HOLD
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     led_blank,
    input  logic [CHANNELS-1:0]      led_xerr_n,
    input  logic                     clear_errors,
    output logic                     status_yellow,
    output logic                     status_orange,
    output logic                     status_red,
    output logic                     stalled,
    output logic [CHANNELS-1:0]      err_sticky,
    output logic [PERIOD_W-1:0]      frame_period,
    output logic                     period_valid,
    output logic [FRAME_COUNT_W-1:0] frame_count
);

    localparam logic [PERIOD_W-1:0] GAP_MAX  = '1;
    localparam logic [PERIOD_W-1:0] WD_LIMIT = PERIOD_W'(WATCHDOG_CYCLES);

    logic                blank_edge;
    logic                blank_prev_q, blank_prev_d;
    logic [BLINK_BIT:0]  blank_count_q, blank_count_d;
    frame_count_t        frame_count_q, frame_count_d;
    logic [PERIOD_W-1:0] gap_q, gap_d;
    logic [PERIOD_W-1:0] frame_period_q, frame_period_d;
    logic                period_valid_q, period_valid_d;
    logic                blank_seen_q, blank_seen_d;
    logic [CHANNELS-1:0] hold_active;

    // Blank rising-edge detection and the counters/measurements it advances.
    always_comb begin
        blank_edge     = led_blank & ~blank_prev_q;
        blank_prev_d   = led_blank;
        blank_count_d  = blank_count_q;
        frame_count_d  = frame_count_q;
        frame_period_d = frame_period_q;
        period_valid_d = period_valid_q;
        blank_seen_d   = blank_seen_q;
        gap_d          = (gap_q == GAP_MAX) ? gap_q : gap_q + 1'b1;
        if (blank_edge) begin
            blank_count_d  = blank_count_q + 1'b1;
            frame_count_d  = frame_count_q + 1'b1;
            frame_period_d = gap_q;
            gap_d          = PERIOD_W'(1);
            // The first edge only starts the gap; a real period needs a previous edge.
            period_valid_d = period_valid_q | blank_seen_q;
            blank_seen_d   = 1'b1;
        end
    end

    // Blank tracking state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blank_prev_q   <= 1'b0;
            blank_count_q  <= '0;
            frame_count_q  <= '0;
            gap_q          <= '0;
            frame_period_q <= '0;
            period_valid_q <= 1'b0;
            blank_seen_q   <= 1'b0;
        end else begin
            blank_prev_q   <= blank_prev_d;
            blank_count_q  <= blank_count_d;
            frame_count_q  <= frame_count_d;
            gap_q          <= gap_d;
            frame_period_q <= frame_period_d;
            period_valid_q <= period_valid_d;
            blank_seen_q   <= blank_seen_d;
        end
    end

    // One stretcher per XERR channel.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_xerr
        xerr_stretch #(
            .ERR_HOLD (ERR_HOLD)
        ) u_xerr_stretch (
            .clock   (clock),
            .reset_n (reset_n),
            .xerr_n  (led_xerr_n[g]),
            .clear   (clear_errors),
            .active  (hold_active[g]),
            .sticky  (err_sticky[g])
        );
    end

    // The watchdog decodes the registered gap, so it is 0 in reset (gap = 0).
    assign stalled       = (gap_q >= WD_LIMIT);
    assign status_orange = stalled;
    assign status_yellow = blank_count_q[BLINK_BIT];
    assign status_red    = |hold_active;
    assign frame_period  = frame_period_q;
    assign period_valid  = period_valid_q;
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_panel_status_monitor.sv
// Self-checking bench for panel_status_monitor with small parameters so the
// watchdog, error stretch and gap saturation are reachable in a short run.
module tb_panel_status_monitor;

    localparam int CH      = 2;
    localparam int BB      = 2;
    localparam int PW      = 8;
    localparam int WD      = 50;
    localparam int EH      = 8;
    localparam int GAP_SAT = (1 << PW) - 1;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          led_blank = 1'b0;
    logic [CH-1:0] led_xerr_n = '1;
    logic          clear_errors = 1'b0;
    logic          status_yellow, status_orange, status_red, stalled;
    logic [CH-1:0] err_sticky;
    logic [PW-1:0] frame_period;
    logic          period_valid;
    logic [15:0]   frame_count;

    panel_status_monitor #(
        .CHANNELS        (CH),
        .BLINK_BIT       (BB),
        .PERIOD_W        (PW),
        .WATCHDOG_CYCLES (WD),
        .ERR_HOLD        (EH)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .led_blank     (led_blank),
        .led_xerr_n    (led_xerr_n),
        .clear_errors  (clear_errors),
        .status_yellow (status_yellow),
        .status_orange (status_orange),
        .status_red    (status_red),
        .stalled       (stalled),
        .err_sticky    (err_sticky),
        .frame_period  (frame_period),
        .period_valid  (period_valid),
        .frame_count   (frame_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (time stamps since reset release) ----------------
    int        m_k;        // clock edges since reset release
    int        m_last;     // edge index of the last blank rising edge (1 = virtual start)
    int        m_edges;    // blank rising edges seen
    int        m_fc_off;   // offset applied when the frame counter is preset
    int        m_period;
    int        m_gap;
    bit        m_valid, m_seen, m_prev;
    bit [CH-1:0] m_sticky;
    bit [CH-1:0] m_low [int]; // which channels were sampled low at each edge index

    function automatic int sat(input int v);
        return (v > GAP_SAT) ? GAP_SAT : v;
    endfunction

    function automatic void mdl_reset();
        m_k = 0; m_last = 1; m_edges = 0; m_fc_off = 0; m_period = 0; m_gap = 0;
        m_valid = 0; m_seen = 0; m_prev = 0; m_sticky = '0;
        m_low.delete();
    endfunction

    // Error from a low sample at index j is visible during edges j+2 .. j+EH+1.
    function automatic bit mdl_red();
        for (int j = m_k - EH - 1; j <= m_k - 2; j++)
            if (j >= 1 && m_low.exists(j) && (m_low[j] != '0)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void mdl_step();
        bit err;
        if (!reset_n) return;
        m_k++;
        m_low[m_k] = ~led_xerr_n;
        if (led_blank && !m_prev) begin
            m_period = sat(m_k - m_last);
            if (m_seen) m_valid = 1'b1;
            m_seen  = 1'b1;
            m_edges++;
            m_last  = m_k;
        end
        m_prev = led_blank;
        m_gap  = sat(m_k + 1 - m_last);
        for (int c = 0; c < CH; c++) begin
            err = (m_k - 2 >= 1) && m_low[m_k-2][c];
            if (err) m_sticky[c] = 1'b1;
            else if (clear_errors) m_sticky[c] = 1'b0;
        end
    endfunction

    task automatic check_all(input string tag);
        bit st;
        st = (m_gap >= WD);
        check({tag, ".yellow"}, 32'(status_yellow), 32'((m_edges >> BB) & 1));
        check({tag, ".stalled"}, 32'(stalled), 32'(st));
        check({tag, ".orange"}, 32'(status_orange), 32'(st));
        check({tag, ".red"}, 32'(status_red), 32'(mdl_red()));
        check({tag, ".sticky"}, 32'(err_sticky), 32'(m_sticky));
        check({tag, ".period"}, 32'(frame_period), 32'(m_period));
        check({tag, ".valid"}, 32'(period_valid), 32'(m_valid));
        check({tag, ".fcount"}, 32'(frame_count), (m_edges + m_fc_off) & 32'hFFFF);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".yellow"}, 32'(status_yellow), 0);
        check({tag, ".stalled"}, 32'(stalled), 0);
        check({tag, ".orange"}, 32'(status_orange), 0);
        check({tag, ".red"}, 32'(status_red), 0);
        check({tag, ".sticky"}, 32'(err_sticky), 0);
        check({tag, ".period"}, 32'(frame_period), 0);
        check({tag, ".valid"}, 32'(period_valid), 0);
        check({tag, ".fcount"}, 32'(frame_count), 0);
    endtask

    // One clock: model follows the inputs sampled at the edge, outputs checked 1 ns later.
    task automatic tick(input string tag);
        @(posedge clock);
        mdl_step();
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input logic b, input logic [CH-1:0] x, input logic clr);
        led_blank = b; led_xerr_n = x; clear_errors = clr;
    endtask

    // Hold reset for 4 clocks (optionally toggling blank) and release with idle inputs.
    task automatic do_reset(input bit toggle);
        reset_n = 1'b0;
        mdl_reset();
        set_in(1'b0, '1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            check_zero("rst");
            if (toggle) led_blank = ~led_blank;
        end
        set_in(1'b0, '1, 1'b0);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic          blank;
        logic [CH-1:0] xn;
        logic          clr;
        logic [15:0]   fc;
        logic          pv;
        logic [PW-1:0] per;
        logic          red;
        logic [CH-1:0] st;
    } vec_t;

    vec_t vecs [12];
    int   n;

    initial begin
        // Hand-derived sequence from reset release: edges at k2 and k6, ch1 errors
        // sampled at k2 and k8, clears at k7 (takes effect) and k10 (loses to the error).
        vecs[0]  = '{1'b0, 2'b11, 1'b0, 16'd0, 1'b0, 8'd0, 1'b0, 2'b00};
        vecs[1]  = '{1'b1, 2'b01, 1'b0, 16'd1, 1'b0, 8'd1, 1'b0, 2'b00};
        vecs[2]  = '{1'b1, 2'b11, 1'b0, 16'd1, 1'b0, 8'd1, 1'b0, 2'b00};
        vecs[3]  = '{1'b0, 2'b11, 1'b0, 16'd1, 1'b0, 8'd1, 1'b1, 2'b10};
        vecs[4]  = '{1'b0, 2'b11, 1'b0, 16'd1, 1'b0, 8'd1, 1'b1, 2'b10};
        vecs[5]  = '{1'b1, 2'b11, 1'b0, 16'd2, 1'b1, 8'd4, 1'b1, 2'b10};
        vecs[6]  = '{1'b0, 2'b11, 1'b1, 16'd2, 1'b1, 8'd4, 1'b1, 2'b00};
        vecs[7]  = '{1'b0, 2'b01, 1'b0, 16'd2, 1'b1, 8'd4, 1'b1, 2'b00};
        vecs[8]  = '{1'b0, 2'b11, 1'b0, 16'd2, 1'b1, 8'd4, 1'b1, 2'b00};
        vecs[9]  = '{1'b0, 2'b11, 1'b1, 16'd2, 1'b1, 8'd4, 1'b1, 2'b10};
        vecs[10] = '{1'b0, 2'b11, 1'b0, 16'd2, 1'b1, 8'd4, 1'b1, 2'b10};
        vecs[11] = '{1'b0, 2'b11, 1'b0, 16'd2, 1'b1, 8'd4, 1'b1, 2'b10};

        #1;
        // 1: reset with blank toggling, then stall latency from release.
        do_reset(1'b1);
        n = 0;
        while (!stalled && n < 200) begin tick("t1"); n++; end
        check("t1.stall_latency", 32'(n), 32'(WD));

        // 2: three edges 20 cycles apart.
        do_reset(1'b0);
        tick("t2");
        for (int e = 1; e <= 3; e++) begin
            led_blank = 1'b1;
            tick("t2");
            if (e == 1) begin
                check("t2.e1_valid", 32'(period_valid), 0);
                check("t2.e1_fcount", 32'(frame_count), 1);
            end else if (e == 2) begin
                check("t2.e2_period", 32'(frame_period), 20);
                check("t2.e2_valid", 32'(period_valid), 1);
            end else begin
                check("t2.e3_fcount", 32'(frame_count), 3);
            end
            led_blank = 1'b0;
            for (int i = 0; i < 19; i++) tick("t2");
        end

        // 3: edge exactly when gap = 49, then let it stall and saturate.
        led_blank = 1'b1; tick("t3");
        led_blank = 1'b0;
        for (int i = 0; i < 48; i++) tick("t3");
        led_blank = 1'b1; tick("t3");
        check("t3.race_stalled", 32'(stalled), 0);
        check("t3.race_period", 32'(frame_period), 49);
        led_blank = 1'b0;
        n = 0;
        while (!stalled && n < 100) begin tick("t3"); n++; end
        check("t3.stall_after_edge", 32'(n), 49);
        for (int i = 0; i < 300; i++) tick("t3");
        led_blank = 1'b1; tick("t3");
        check("t3.sat_period", 32'(frame_period), 255);
        check("t3.stall_cleared", 32'(stalled), 0);
        led_blank = 1'b0; tick("t3");

        // 4: heartbeat over 8 edges, then frame counter wrap from a preset value.
        do_reset(1'b0);
        tick("t4");
        for (int e = 1; e <= 8; e++) begin
            led_blank = 1'b1; tick("t4");
            if (e == 3) check("t4.yellow_e3", 32'(status_yellow), 0);
            if (e == 4) check("t4.yellow_e4", 32'(status_yellow), 1);
            if (e == 7) check("t4.yellow_e7", 32'(status_yellow), 1);
            if (e == 8) check("t4.yellow_e8", 32'(status_yellow), 0);
            led_blank = 1'b0; tick("t4"); tick("t4");
        end
        force dut.frame_count_q = 16'hFFFE;
        m_fc_off = 32'hFFFE - m_edges;
        #1;
        release dut.frame_count_q;
        tick("t4");
        led_blank = 1'b1; tick("t4");
        check("t4.fc_ffff", 32'(frame_count), 32'hFFFF);
        led_blank = 1'b0; tick("t4");
        led_blank = 1'b1; tick("t4");
        check("t4.fc_wrap", 32'(frame_count), 0);
        led_blank = 1'b0; tick("t4");

        // 5: table of error / sticky / period vectors from a fresh reset.
        do_reset(1'b0);
        for (int i = 0; i < 12; i++) begin
            set_in(vecs[i].blank, vecs[i].xn, vecs[i].clr);
            tick("t5m");
            check($sformatf("t5[%0d].fcount", i), 32'(frame_count), 32'(vecs[i].fc));
            check($sformatf("t5[%0d].valid", i), 32'(period_valid), 32'(vecs[i].pv));
            check($sformatf("t5[%0d].period", i), 32'(frame_period), 32'(vecs[i].per));
            check($sformatf("t5[%0d].red", i), 32'(status_red), 32'(vecs[i].red));
            check($sformatf("t5[%0d].sticky", i), 32'(err_sticky), 32'(vecs[i].st));
        end
        set_in(1'b0, '1, 1'b0);
        for (int i = 0; i < 10; i++) tick("t5");
        set_in(1'b0, 2'b01, 1'b0); tick("t5");
        set_in(1'b0, 2'b11, 1'b0);
        n = 0;
        for (int i = 0; i < 20; i++) begin tick("t5"); if (status_red) n++; end
        check("t5.red_width", 32'(n), 32'(EH));

        // 6: asynchronous reset while red is held, then a quiet release.
        set_in(1'b0, 2'b10, 1'b0); tick("t6");
        set_in(1'b0, 2'b11, 1'b0); tick("t6"); tick("t6");
        check("t6.red_before", 32'(status_red), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("t6.async");
        do_reset(1'b0);
        n = 0;
        for (int i = 0; i < 12; i++) begin tick("t6"); if (status_red) n++; end
        check("t6.no_glitch", 32'(n), 0);

        // Random: alternating busy/quiet blank phases, sparse errors and clears.
        do_reset(1'b0);
        for (int blk = 0; blk < 8; blk++) begin
            for (int i = 0; i < 150; i++) begin
                if (blk % 2 == 0) led_blank = ($urandom_range(0, 3) == 0);
                else              led_blank = ($urandom_range(0, 79) == 0);
                for (int c = 0; c < CH; c++) led_xerr_n[c] = ($urandom_range(0, 19) != 0);
                clear_errors = ($urandom_range(0, 15) == 0);
                tick("rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
